// File: rtl/isp_pkg.sv
// Shared ISP definitions: the RGB pixel type and the GBRG Bayer channel map used by
// the mosaic, the demosaic and their benches.
package isp_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        BAYER_R,
        BAYER_G,
        BAYER_B
    } bayer_chan_e;

    // GBRG: even rows G B G B, odd rows R G R G
    function automatic bayer_chan_e bayer_chan(input logic row_lsb, input logic col_lsb);
        bayer_chan_e ch;
        if (row_lsb == col_lsb) begin
            ch = BAYER_G;
        end else if (row_lsb) begin
            ch = BAYER_R;
        end else begin
            ch = BAYER_B;
        end
        return ch;
    endfunction

    function automatic logic [7:0] bayer_pick(input rgb_t px, input bayer_chan_e ch);
        logic [7:0] sample;
        case (ch)
            BAYER_R: sample = px.r;
            BAYER_B: sample = px.b;
            default: sample = px.g;
        endcase
        return sample;
    endfunction

endpackage

// File: rtl/bayer_mosaic_if.sv
// Pixel-stream bundle for the Bayer mosaic: RGB pixels in, RAW samples with raster
// position and frame markers out.
interface bayer_mosaic_if #(
    parameter int width  = 320,
    parameter int height = 240
) ();
    localparam int ColW = $clog2(width);
    localparam int RowW = $clog2(height);

    logic            iValid;
    logic [7:0]      iR;
    logic [7:0]      iG;
    logic [7:0]      iB;
    logic            oValid;
    logic [7:0]      oData;
    logic [RowW-1:0] oRow;
    logic [ColW-1:0] oCol;
    logic            oSof;
    logic            oEol;
    logic            oDone;

    modport slave (
        input  iValid, iR, iG, iB,
        output oValid, oData, oRow, oCol, oSof, oEol, oDone
    );

    modport master (
        output iValid, iR, iG, iB,
        input  oValid, oData, oRow, oCol, oSof, oEol, oDone
    );
endinterface

// File: rtl/raster_counter.sv
// Raster position tracker: col/row of the pixel accepted this cycle, plus start-of-frame,
// end-of-line and end-of-frame markers for that position. Advances only on advance_i.
module raster_counter #(
    parameter  int width  = 320,
    parameter  int height = 240,
    localparam int ColW   = $clog2(width),
    localparam int RowW   = $clog2(height)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance_i,
    output logic [ColW-1:0] col_o,
    output logic [RowW-1:0] row_o,
    output logic            sof_o,
    output logic            eol_o,
    output logic            eof_o
);
    localparam logic [ColW-1:0] ColLast = ColW'(width - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(height - 1);

    logic [ColW-1:0] col_d, col_q;
    logic [RowW-1:0] row_d, row_q;

    assign col_o = col_q;
    assign row_o = row_q;
    assign sof_o = (col_q == '0) && (row_q == '0);
    assign eol_o = (col_q == ColLast);
    assign eof_o = eol_o && (row_q == RowLast);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        col_d = col_q;
        row_d = row_q;
        if (advance_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/bayer_mosaic.sv
// RGB to GBRG Bayer RAW converter: two register stages (capture, then channel select),
// fixed 2-cycle latency, raster position and frame markers travel with each sample.
module bayer_mosaic
    import isp_pkg::*;
#(
    parameter int width  = 320,
    parameter int height = 240
) (
    input logic           clk,
    input logic           reset,
    bayer_mosaic_if.slave bus
);
    localparam int ColW = $clog2(width);
    localparam int RowW = $clog2(height);

    typedef struct packed {
        logic            valid;
        rgb_t            px;
        logic [ColW-1:0] col;
        logic [RowW-1:0] row;
        logic            sof;
        logic            eol;
        logic            eof;
    } stage1_t;

    typedef struct packed {
        logic            valid;
        logic [7:0]      data;
        logic [ColW-1:0] col;
        logic [RowW-1:0] row;
        logic            sof;
        logic            eol;
        logic            done;
    } stage2_t;

    logic [ColW-1:0] cnt_col;
    logic [RowW-1:0] cnt_row;
    logic            cnt_sof;
    logic            cnt_eol;
    logic            cnt_eof;

    stage1_t s1_d, s1_q;
    stage2_t s2_d, s2_q;

    raster_counter #(
        .width (width),
        .height(height)
    ) u_raster (
        .clk      (clk),
        .reset    (reset),
        .advance_i(bus.iValid),
        .col_o    (cnt_col),
        .row_o    (cnt_row),
        .sof_o    (cnt_sof),
        .eol_o    (cnt_eol),
        .eof_o    (cnt_eof)
    );

    always_comb begin
        s1_d.valid = bus.iValid;
        s1_d.px.r  = bus.iR;
        s1_d.px.g  = bus.iG;
        s1_d.px.b  = bus.iB;
        s1_d.col   = cnt_col;
        s1_d.row   = cnt_row;
        s1_d.sof   = cnt_sof;
        s1_d.eol   = cnt_eol;
        s1_d.eof   = cnt_eof;
    end

    // Markers are gated by valid; data and position hold through gaps.
    always_comb begin
        s2_d       = s2_q;
        s2_d.valid = s1_q.valid;
        s2_d.sof   = s1_q.valid & s1_q.sof;
        s2_d.eol   = s1_q.valid & s1_q.eol;
        s2_d.done  = s1_q.valid & s1_q.eof;
        if (s1_q.valid) begin
            s2_d.data = bayer_pick(s1_q.px, bayer_chan(s1_q.row[0], s1_q.col[0]));
            s2_d.col  = s1_q.col;
            s2_d.row  = s1_q.row;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign bus.oValid = s2_q.valid;
    assign bus.oData  = s2_q.data;
    assign bus.oRow   = s2_q.row;
    assign bus.oCol   = s2_q.col;
    assign bus.oSof   = s2_q.sof;
    assign bus.oEol   = s2_q.eol;
    assign bus.oDone  = s2_q.done;

endmodule
